// File: rtl/calc_seq_core.sv
// Calculator sequencer: debounced mode/compute buttons, a small IDLE/BUSY/SHOW
// FSM, and one-cycle add/sub plus W-cycle shift-add multiply and restoring divide.

// Button conditioner: 2-flop synchronizer, counter debounce, press pulse on 1->0.
module calc_seq_debounce #(
    parameter int DBNC = 4
) (
    input  logic clock,
    input  logic btn_reset,
    input  logic btn,
    output logic press
);
    localparam int CW = $clog2(DBNC + 1);

    logic          s1, s2, level, level_d;
    logic [CW-1:0] cnt;

    // Level only moves after DBNC consecutive samples that disagree with it.
    always_ff @(posedge clock or negedge btn_reset) begin
        if (!btn_reset) begin
            s1      <= 1'b1;
            s2      <= 1'b1;
            level   <= 1'b1;
            level_d <= 1'b1;
            cnt     <= '0;
        end else begin
            s1      <= btn;
            s2      <= s1;
            level_d <= level;
            if (s2 == level) begin
                cnt <= '0;
            end else if (cnt == CW'(DBNC - 1)) begin
                level <= s2;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // One pulse per debounced press; holding gives no repeats.
    assign press = level_d & ~level;
endmodule

module calc_seq_core #(
    parameter int W    = 4,
    parameter int DBNC = 4
) (
    input  logic           clock,
    input  logic           btn_reset,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    input  logic           btn_modo,
    input  logic           btn_res,
    output logic [2*W-1:0] result,
    output logic           led_alerta,
    output logic [3:0]     led_modo,
    output logic           busy,
    output logic           done
);
    typedef enum logic [1:0] {IDLE, BUSY, SHOW} state_t;

    localparam logic [1:0] MODE_ADD = 2'd0;
    localparam logic [1:0] MODE_SUB = 2'd1;
    localparam logic [1:0] MODE_MUL = 2'd2;
    localparam int         CW       = $clog2(W + 1);

    state_t         state;
    logic [1:0]     mode, op_mode;
    logic [W-1:0]   op_a, op_b;
    logic [2*W-1:0] mc, acc;
    logic [W-1:0]   mq, rem, quo;
    logic [CW-1:0]  step;
    logic           last;

    logic [1:0] btns, presses;
    logic       modo_evt, res_evt;

    assign btns = {btn_res, btn_modo};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            calc_seq_debounce #(.DBNC(DBNC)) u_dbnc (
                .clock    (clock),
                .btn_reset(btn_reset),
                .btn      (btns[gi]),
                .press    (presses[gi])
            );
        end
    endgenerate

    assign modo_evt = presses[0];
    assign res_evt  = presses[1];

    logic [2*W-1:0] sum_ext, diff_ext, acc_nxt;
    logic [W:0]     rem_sh;
    logic [W-1:0]   rem_nxt, quo_nxt;
    logic           quo_bit;

    // Next-step values for the one-cycle ops and one iteration of mul/div.
    always_comb begin
        sum_ext  = {{W{1'b0}}, op_a} + {{W{1'b0}}, op_b};
        diff_ext = (op_a >= op_b) ? {{W{1'b0}}, op_a - op_b} : {{W{1'b0}}, op_b - op_a};
        acc_nxt  = mq[0] ? acc + mc : acc;
        // Restoring divide: shift next dividend bit in, subtract if it fits.
        rem_sh   = {rem, quo[W-1]};
        quo_bit  = (rem_sh >= {1'b0, op_b});
        rem_nxt  = quo_bit ? W'(rem_sh - {1'b0, op_b}) : rem_sh[W-1:0];
        quo_nxt  = {quo[W-2:0], quo_bit};
        last     = (step == CW'(W - 1));
    end

    // Main FSM; operands are latched on the res event so a/b may change mid-op.
    always_ff @(posedge clock or negedge btn_reset) begin
        if (!btn_reset) begin
            state      <= IDLE;
            mode       <= MODE_ADD;
            op_mode    <= MODE_ADD;
            op_a       <= '0;
            op_b       <= '0;
            mc         <= '0;
            mq         <= '0;
            acc        <= '0;
            rem        <= '0;
            quo        <= '0;
            step       <= '0;
            result     <= '0;
            led_alerta <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE, SHOW: begin
                    // res wins a tie with modo; modo is then dropped.
                    if (res_evt) begin
                        op_a       <= a;
                        op_b       <= b;
                        op_mode    <= mode;
                        mc         <= {{W{1'b0}}, a};
                        mq         <= b;
                        acc        <= '0;
                        rem        <= '0;
                        quo        <= a;
                        step       <= '0;
                        led_alerta <= 1'b0;
                        state      <= BUSY;
                    end else if (modo_evt) begin
                        mode <= mode + 2'd1;
                    end
                end
                BUSY: begin
                    step <= step + 1'b1;
                    acc  <= acc_nxt;
                    mc   <= mc << 1;
                    mq   <= mq >> 1;
                    rem  <= rem_nxt;
                    quo  <= quo_nxt;
                    case (op_mode)
                        MODE_ADD: begin
                            result <= sum_ext;
                            done   <= 1'b1;
                            state  <= SHOW;
                        end
                        MODE_SUB: begin
                            result     <= diff_ext;
                            led_alerta <= (op_a < op_b);
                            done       <= 1'b1;
                            state      <= SHOW;
                        end
                        MODE_MUL: begin
                            if (last) begin
                                result <= acc_nxt;
                                done   <= 1'b1;
                                state  <= SHOW;
                            end
                        end
                        default: begin
                            if (op_b == '0) begin
                                result     <= '0;
                                led_alerta <= 1'b1;
                                done       <= 1'b1;
                                state      <= SHOW;
                            end else if (last) begin
                                result <= {rem_nxt, quo_nxt};
                                done   <= 1'b1;
                                state  <= SHOW;
                            end
                        end
                    endcase
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy     = (state == BUSY);
    assign led_modo = {mode == 2'd3, mode >= 2'd2, mode >= 2'd1, 1'b1};
endmodule

// File: doc/calc_seq_core.md
CALC_SEQ_CORE -- requirements
Module: calc_seq_core

Interface
REQ-001 SHALL provide parameter W, default 4, giving the operand width in bits (legal 2..16).
REQ-002 SHALL provide parameter DBNC, default 4, giving the debounce length in clock cycles (legal >=1).
REQ-003 SHALL have port clock, input, 1 bit: the single clock; every flop is rising-edge.
REQ-004 SHALL have port btn_reset, input, 1 bit: one clock; reset is asynchronous and active-low.
REQ-005 SHALL have port a, input, W bits: operand A, unsigned.
REQ-006 SHALL have port b, input, W bits: operand B, unsigned.
REQ-007 SHALL have port btn_modo, input, 1 bit: mode button, active-low, asynchronous to clock.
REQ-008 SHALL have port btn_res, input, 1 bit: compute button, active-low, asynchronous to clock.
REQ-009 SHALL have port result, output, 2W bits: the last computed result.
REQ-010 SHALL have port led_alerta, output, 1 bit: alert flag for a negative difference or a divide by zero.
REQ-011 SHALL have port led_modo, output, 4 bits: thermometer display of the current mode.
REQ-012 SHALL have port busy, output, 1 bit: high while a computation is in progress.
REQ-013 SHALL have port done, output, 1 bit: one-cycle pulse when a result is committed.

Function
REQ-014 Each button SHALL pass through a 2-flop synchronizer.
- The debounced level SHALL change only after DBNC consecutive identical synchronized samples.
- A press event SHALL be a single-cycle pulse on the debounced high-to-low transition.
- Holding a button SHALL NOT produce repeat events.
REQ-015 Mode SHALL be a 2-bit register: 0=add, 1=sub, 2=mul, 3=div.
- A modo event in IDLE or SHOW SHALL increment the mode, wrapping 3 to 0.
- A modo event in BUSY SHALL be discarded.
REQ-016 led_modo[0] SHALL always be 1, and led_modo[k] SHALL be 1 when mode >= k (k = 1..3).
REQ-017 The state machine SHALL have the states IDLE, BUSY and SHOW.
REQ-018 A res event in IDLE or SHOW SHALL do the following in that cycle:
- capture a, b and mode into internal registers;
- clear led_alerta;
- enter BUSY.
REQ-019 A res event in BUSY SHALL be ignored.
REQ-020 If res and modo events coincide in IDLE or SHOW, res SHALL take priority, the computation SHALL use the pre-event mode, and the modo event SHALL be discarded.
REQ-021 Changes on a and b during BUSY SHALL NOT affect the result in flight.
REQ-022 Add SHALL occupy 1 BUSY cycle; result = a+b, zero-extended to 2W bits.
REQ-023 Sub SHALL occupy 1 BUSY cycle:
- a>=b: result = a-b, led_alerta=0;
- a<b: result = b-a, led_alerta=1.
REQ-024 Mul SHALL be an iterative shift-add occupying exactly W BUSY cycles; result = full 2W-bit product.
REQ-025 Div with b!=0 SHALL be a restoring divider occupying exactly W BUSY cycles:
- result[W-1:0] = quotient;
- result[2W-1:W] = remainder.
REQ-026 Div with b==0 SHALL occupy 1 BUSY cycle, with result=0 and led_alerta=1.
REQ-027 On the last BUSY cycle, the FSM SHALL:
- update result and led_alerta at the next rising edge;
- pulse done for exactly that following cycle;
- enter SHOW.
REQ-028 result SHALL hold its value through SHOW and during the next BUSY, changing only when a result is committed or on reset.
REQ-029 led_alerta SHALL hold from commit until the next res event or reset.
REQ-030 busy SHALL equal (state==BUSY).
REQ-031 IDLE SHALL be left only by a res event; SHOW SHALL be left only by a res event or reset.

Reset
REQ-032 btn_reset low SHALL immediately force the following, regardless of clock:
- state=IDLE, mode=0;
- result=0, led_alerta=0, busy=0, done=0;
- led_modo=4'b0001;
- debouncers to the released (high) level.
REQ-033 Reset asserted during BUSY SHALL abort the operation, with no done pulse and no result update.
REQ-034 After reset deasserts, the first event SHALL require a full synchronizer plus DBNC debounce interval.

Verification
REQ-035 W=4, DBNC=2: bounce btn_res low/high/low at 1-cycle intervals, then hold low -> exactly one res event and exactly one done pulse.
REQ-036 W=4, mode=1, a=3, b=9, res -> busy for 1 cycle, then result=6, led_alerta=1, done pulsed once.
REQ-037 W=8, mode=2, a=255, b=255, res -> busy for exactly 8 cycles, then result=16'hFE01.
REQ-038 W=8, mode=3:
- a=200, b=7 -> after 8 busy cycles, result[7:0]=28 and result[15:8]=4;
- b=0 -> 1 busy cycle, result=0, led_alerta=1.
REQ-039 Press modo 5 times from reset -> led_modo sequence 0011, 0111, 1111, 0001, 0011; modo presses during BUSY -> led_modo unchanged.
REQ-040 Assert btn_reset in the 3rd cycle of an 8-cycle mul -> result=0 and state=IDLE immediately, no done pulse; a subsequent res (mode 0, a=1, b=2) -> result=3.
